// File: rtl/ss_xfer_engine.sv
// ss_xfer_engine: save-state sequencer that streams mapper state bytes to and from the host, paced by cartridge M2.
// Optional feature: define SS_TMO_EN to abort a transfer with err when M2 stops toggling for TMO_CYC clk cycles.
module ss_xfer_engine #(
    parameter int SS_LEN  = 128,
    parameter int TMO_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       save_req,
    input  logic       rest_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tx_dat,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_dat,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat
);
    typedef enum logic [2:0] {IDLE, ACT_IN, RD_SETTLE, RD_SEND, WR_WAIT, WR_STRB, ACT_OUT} state_t;

    localparam logic [7:0] LAST = 8'(SS_LEN - 1);

    state_t     state;
    logic       is_save;
    logic [2:0] m2_sync;
    logic       m2_fall;
    logic       last;
    logic       tmo_hit;

    assign m2_fall = m2_sync[2] & ~m2_sync[1];
    assign last    = ss_addr == LAST;

    // two-flop synchronizer on m2 plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m2_sync <= '0;
        else m2_sync <= {m2_sync[1:0], m2};
    end

`ifdef SS_TMO_EN
    localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_wait;

    assign tmo_wait = state inside {ACT_IN, RD_SETTLE, WR_STRB, ACT_OUT};
    assign tmo_hit  = tmo_wait & ~m2_fall & (tmo_cnt == TMO_LIM);

    // count clk cycles spent waiting for an M2 fall; every state change happens on a fall or from a non-waiting state, so the count restarts per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else tmo_cnt <= (tmo_wait && !m2_fall) ? tmo_cnt + 16'd1 : '0;
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = TMO_CYC == 0;
`endif

    // transfer sequencer; all mapper-side steps advance on m2_fall, host-side steps on the handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_save  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tx_dat   <= '0;
            tx_valid <= 1'b0;
            rx_ready <= 1'b0;
            ss_act   <= 1'b0;
            ss_we    <= 1'b0;
            ss_addr  <= '0;
            ss_wdat  <= '0;
        end else begin
            done <= 1'b0;
            err  <= tmo_hit;
            case (state)
                IDLE: if (save_req || rest_req) begin
                    is_save <= save_req;
                    busy    <= 1'b1;
                    ss_act  <= 1'b1;
                    ss_addr <= '0;
                    state   <= ACT_IN;
                end
                ACT_IN: if (m2_fall) begin
                    rx_ready <= !is_save;
                    state    <= is_save ? RD_SETTLE : WR_WAIT;
                end
                RD_SETTLE: if (m2_fall) begin
                    tx_dat   <= ss_rdat;
                    tx_valid <= 1'b1;
                    state    <= RD_SEND;
                end
                RD_SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    ss_addr  <= last ? ss_addr : ss_addr + 8'd1;
                    state    <= last ? ACT_OUT : RD_SETTLE;
                end
                WR_WAIT: if (rx_valid) begin
                    ss_wdat  <= rx_dat;
                    rx_ready <= 1'b0;
                    ss_we    <= 1'b1;
                    state    <= WR_STRB;
                end
                WR_STRB: if (m2_fall) begin
                    ss_we    <= 1'b0;
                    rx_ready <= !last;
                    ss_addr  <= last ? ss_addr : ss_addr + 8'd1;
                    state    <= last ? ACT_OUT : WR_WAIT;
                end
                ACT_OUT: if (m2_fall) begin
                    ss_act <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (tmo_hit) begin
                ss_we  <= 1'b0;
                ss_act <= 1'b0;
                busy   <= 1'b0;
                state  <= IDLE;
            end
        end
    end
endmodule
